// File: rtl/add_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : add_share_arb
//  Purpose  : Round-robin arbiter / sequencer sharing one external registered
//             adder (enable-gated, one-cycle latency) among NREQ requesters.
//             Each issued operation is tagged with its requester id and the
//             adder result is returned on a single backpressured response
//             channel. A saturating counter tracks accepted overflow results.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        system clock, rising edge
//    reset      in   1        asynchronous active-high reset
//    req_valid  in   NREQ     per-requester request valid
//    req_a      in   NREQ*W   operand A, requester i at [i*W +: W]
//    req_b      in   NREQ*W   operand B, same packing
//    req_ready  out  NREQ     one-hot grant
//    add_in1    out  W        adder operand 1
//    add_in2    out  W        adder operand 2
//    add_en     out  1        adder enable
//    add_sum    in   W        adder registered sum
//    add_overf  in   1        adder registered signed overflow
//    rsp_valid  out  1        response valid
//    rsp_ready  in   1        response consumer ready
//    rsp_id     out  IDW      requester index of current response
//    rsp_sum    out  W        response sum (adder pass-through)
//    rsp_overf  out  1        response overflow (adder pass-through)
//    ovf_cnt    out  CNTW     saturating count of accepted overflow results
//    ovf_clr    in   1        synchronous clear of ovf_cnt (beats increment)
// ============================================================================
module add_share_arb #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = 2,
   parameter int CNTW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [W-1:0]      add_in1,
   output logic [W-1:0]      add_in2,
   output logic              add_en,
   input  logic [W-1:0]      add_sum,
   input  logic              add_overf,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_sum,
   output logic              rsp_overf,
   output logic [CNTW-1:0]   ovf_cnt,
   input  logic              ovf_clr
);

   localparam int NID = 2 ** IDW;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [IDW-1:0]  ptr_q,       ptr_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
   logic [CNTW-1:0] ovf_cnt_q,   ovf_cnt_d;

   // ------------------------------------------------------------------------
   // Combinational arbitration
   // ------------------------------------------------------------------------
   logic [NID-1:0]  valid_ext;
   logic [IDW:0]    scan_idx;
   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic            can_issue;
   logic            issue;
   logic            rsp_accept;

   // The adder register is the only result storage, so a new operation may
   // only start when the current response leaves (or none is held).
   assign can_issue  = !rsp_valid_q || rsp_ready;
   assign rsp_accept = rsp_valid_q && rsp_ready;

   always_comb begin
      // Pad the valid vector to the full id space so the scan index can be
      // used directly without an out-of-range select.
      valid_ext              = '0;
      valid_ext[NREQ-1:0]    = req_valid;
      scan_idx               = '0;
      grant_found            = 1'b0;
      grant_idx              = '0;
      for (int k = 0; k < NREQ; k++) begin
         // ptr_q < NREQ and k < NREQ, so one conditional subtract wraps it.
         scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
         if (scan_idx >= (IDW+1)'(NREQ)) begin
            scan_idx = scan_idx - (IDW+1)'(NREQ);
         end
         if (!grant_found && valid_ext[scan_idx[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[IDW-1:0];
         end
      end
   end

   // Grants are suppressed while reset is asserted so the handshake outputs
   // read as idle even though they are combinational.
   assign issue = !reset && can_issue && grant_found;

   // Grant vector and operand mux; operands are forced to zero when idle.
   always_comb begin
      req_ready = '0;
      add_in1   = '0;
      add_in2   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (issue && (grant_idx == IDW'(i))) begin
            req_ready[i] = 1'b1;
            add_in1      = req_a[i*W +: W];
            add_in2      = req_b[i*W +: W];
         end
      end
   end

   assign add_en = issue;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      ovf_cnt_d   = ovf_cnt_q;

      if (issue) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = grant_idx;
         if (grant_idx == IDW'(NREQ-1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx + 1'b1;
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      if (ovf_clr) begin
         ovf_cnt_d = '0;
      end else if (rsp_accept && add_overf && (ovf_cnt_q != {CNTW{1'b1}})) begin
         ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         ovf_cnt_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         ovf_cnt_q   <= ovf_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // Stale adder contents after reset are harmless: rsp_valid gates them.
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = add_sum;
   assign rsp_overf = add_overf;
   assign ovf_cnt   = ovf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_add_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_share_arb
//  Purpose  : Self-checking bench for add_share_arb. Contains a behavioural
//             registered adder and a transaction-level reference model that
//             is compared against the DUT on every falling clock edge, plus
//             directed scenarios with hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_share_arb;

   localparam int NREQ = 4;
   localparam int W    = 16;
   localparam int IDW  = 2;
   localparam int CNTW = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [W-1:0]      add_in1;
   logic [W-1:0]      add_in2;
   logic              add_en;
   logic [W-1:0]      add_sum;
   logic              add_overf;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_sum;
   logic              rsp_overf;
   logic [CNTW-1:0]   ovf_cnt;
   logic              ovf_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   add_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .add_in1   (add_in1),
      .add_in2   (add_in2),
      .add_en    (add_en),
      .add_sum   (add_sum),
      .add_overf (add_overf),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_overf (rsp_overf),
      .ovf_cnt   (ovf_cnt),
      .ovf_clr   (ovf_clr)
   );

   // Shared external adder: registered, enable-gated, no reset.
   initial begin
      add_sum   = '0;
      add_overf = 1'b0;
   end
   always @(posedge clk) begin
      if (add_en) begin
         add_sum   <= add_in1 + add_in2;
         add_overf <= (add_in1[W-1] == add_in2[W-1]) &&
                      (((add_in1 + add_in2) & 16'h8000) != {add_in1[W-1], 15'b0});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // -------------------------------------------------------------------------
   // Reference model: pointer, one pending response, overflow count.
   // Evaluated on each falling edge with the inputs that the next rising
   // edge will see.
   // -------------------------------------------------------------------------
   int m_ptr = 0;
   bit m_rv  = 0;
   int m_id  = 0;
   int m_sum = 0;
   bit m_ovf = 0;
   int m_cnt = 0;

   always @(negedge clk) begin
      int g, idx, a, b, s;
      bit can, iss;
      if (reset) begin
         m_ptr = 0; m_rv = 0; m_id = 0; m_cnt = 0;
         chk("m_rst_ready", req_ready, 0);
         chk("m_rst_en", add_en, 0);
         chk("m_rst_in1", add_in1, 0);
         chk("m_rst_in2", add_in2, 0);
         chk("m_rst_rv", rsp_valid, 0);
         chk("m_rst_id", rsp_id, 0);
         chk("m_rst_cnt", ovf_cnt, 0);
      end else begin
         can = !m_rv || rsp_ready;
         g = -1;
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
         iss = can && (g >= 0);
         a = iss ? int'(req_a[g*W +: W]) : 0;
         b = iss ? int'(req_b[g*W +: W]) : 0;
         chk("m_ready", req_ready, iss ? (1 << g) : 0);
         chk("m_en", add_en, iss);
         chk("m_in1", add_in1, a);
         chk("m_in2", add_in2, b);
         chk("m_rv", rsp_valid, m_rv);
         chk("m_id", rsp_id, m_id);
         chk("m_cnt", ovf_cnt, m_cnt);
         if (m_rv) begin
            chk("m_sum", rsp_sum, m_sum);
            chk("m_ovf", rsp_overf, m_ovf);
         end
         // advance
         if (ovf_clr) m_cnt = 0;
         else if (m_rv && rsp_ready && m_ovf && m_cnt < 255) m_cnt++;
         if (iss) begin
            s     = (a + b) & 16'hFFFF;
            m_rv  = 1;
            m_id  = g;
            m_sum = s;
            m_ovf = (a[15] == b[15]) && (s[15] != a[15]);
            m_ptr = (g + 1) % NREQ;
         end else if (rsp_ready) begin
            m_rv = 0;
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // -------------------------------------------------------------------------
   // Stimulus with directed hand-computed checks
   // -------------------------------------------------------------------------
   initial begin
      logic [W-1:0] ra, rb;
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      ovf_clr   = 1'b0;
      repeat (3) step();
      reset = 1'b0;

      // Idle after reset
      repeat (10) step();
      @(negedge clk);
      chk("idle_ready", req_ready, 0);
      chk("idle_rv", rsp_valid, 0);
      chk("idle_cnt", ovf_cnt, 0);

      // Single request from requester 2
      step();
      set_req(2, 16'h1234, 16'h0101);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("single_ready", req_ready, 4'b0100);
      chk("single_en", add_en, 1);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("single_rv", rsp_valid, 1);
      chk("single_id", rsp_id, 2);
      chk("single_sum", rsp_sum, 16'h1335);
      chk("single_ovf", rsp_overf, 0);

      // Requester 3 alone moves the pointer back to 0
      step();
      set_req(3, 16'h0003, 16'h0004);
      req_valid = 4'b1000;
      step();
      req_valid = '0;

      // All requesters valid: grants rotate 0,1,2,3,0
      for (int i = 0; i < NREQ; i++) set_req(i, 16'(i * 16'h0100), 16'(i + 1));
      step();
      req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_grant", req_ready, 1 << (i % 4));
         if (i > 0) chk("rr_id", rsp_id, (i - 1) % 4);
         step();
      end
      req_valid = '0;
      @(negedge clk);
      chk("rr_id_last", rsp_id, 0);

      // Overflow on requester 1 (pointer is now 1)
      step();
      set_req(1, 16'h7FFF, 16'h0001);
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      @(negedge clk);
      chk("ovf_sum", rsp_sum, 16'h8000);
      chk("ovf_flag", rsp_overf, 1);
      chk("ovf_cnt0", ovf_cnt, 0);
      step();
      @(negedge clk);
      chk("ovf_cnt1", ovf_cnt, 1);

      // Clear and overflow accept in the same cycle: clear wins
      step();
      set_req(2, 16'h7FFF, 16'h0001);
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      ovf_clr   = 1'b1;
      @(negedge clk);
      chk("clr_ovf_flag", rsp_overf, 1);
      step();
      ovf_clr = 1'b0;
      @(negedge clk);
      chk("clr_cnt", ovf_cnt, 0);

      // Backpressure for 3 cycles while requester 1 waits
      step();
      set_req(0, 16'h1111, 16'h2222);
      req_valid = 4'b0001;
      step();
      set_req(1, 16'h0010, 16'h0020);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready", req_ready, 0);
         chk("bp_en", add_en, 0);
         chk("bp_rv", rsp_valid, 1);
         chk("bp_id", rsp_id, 0);
         chk("bp_sum", rsp_sum, 16'h3333);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_regrant", req_ready, 4'b0010);
      chk("bp_regrant_en", add_en, 1);
      step();
      req_valid = '0;

      // Asynchronous reset while a response is valid (pointer is now 2)
      #1;
      req_valid = 4'b1010;
      reset     = 1'b1;
      #1;
      chk("arst_rv", rsp_valid, 0);
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("arst_grant", req_ready, 4'b0010);
      step();
      req_valid = '0;

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         step();
         reset     = ($urandom % 600) == 0;
         req_valid = 4'($urandom);
         rsp_ready = ($urandom % 4) != 0;
         ovf_clr   = ($urandom % 32) == 0;
         for (int i = 0; i < NREQ; i++) begin
            case ($urandom % 4)
               0:       ra = 16'h7FFF;
               1:       ra = 16'h8000;
               default: ra = 16'($urandom);
            endcase
            rb = ($urandom % 3 == 0) ? ra : 16'($urandom);
            set_req(i, ra, rb);
         end
      end
      step();
      reset     = 1'b0;
      ovf_clr   = 1'b0;
      rsp_ready = 1'b1;

      // Drive the counter into saturation
      set_req(0, 16'h7FFF, 16'h0001);
      req_valid = 4'b0001;
      repeat (300) step();
      @(negedge clk);
      chk("sat_cnt", ovf_cnt, 255);
      step();
      req_valid = '0;
      ovf_clr   = 1'b1;
      step();
      ovf_clr = 1'b0;
      @(negedge clk);
      chk("sat_clr", ovf_cnt, 0);

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
